// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I load/store sequencer (IDLE/REQ/WAIT/DONE). Optional macro
//            MISALIGN_TRAP_EN adds a 'misaligned' output and trap path.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
  parameter int RDATA_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        done,
  output logic [31:0] loadData,
  output logic [31:0] memAddr,
  output logic        memRstrb,
  input  logic [31:0] memRData,
  output logic [31:0] memWData,
`ifdef MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic [3:0]  memWMask
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(RDATA_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        isStore_q, isStore_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] storeData_q, storeData_d;
  logic [31:0] loadData_q, loadData_d;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [3:0]  w_mask;

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic w_mis_in;
  assign w_mis_in = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    (funct3[1] && (addr[1:0] != 2'b00));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      isStore_q   <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'd0;
      storeData_q <= 32'd0;
      loadData_q  <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      isStore_q   <= isStore_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      storeData_q <= storeData_d;
      loadData_q  <= loadData_d;
`ifdef MISALIGN_TRAP_EN
      mis_q       <= mis_d;
`endif
    end
  end

  // Lane selection for loads; word accesses ignore the low address bits.
  always_comb begin
    w_byte = memRData[7:0];
    case (addr_q[1:0])
      2'd0: w_byte = memRData[7:0];
      2'd1: w_byte = memRData[15:8];
      2'd2: w_byte = memRData[23:16];
      2'd3: w_byte = memRData[31:24];
      default: w_byte = memRData[7:0];
    endcase
    w_half = addr_q[1] ? memRData[31:16] : memRData[15:0];
    case (funct3_q)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = memRData;
    endcase
  end

  always_comb begin
    w_mask   = 4'b1111;
    memWData = storeData_q;
    case (funct3_q[1:0])
      2'b00: begin
        w_mask   = 4'b0001 << addr_q[1:0];
        memWData = {4{storeData_q[7:0]}};
      end
      2'b01: begin
        w_mask   = addr_q[1] ? 4'b1100 : 4'b0011;
        memWData = {2{storeData_q[15:0]}};
      end
      default: begin
        w_mask   = 4'b1111;
        memWData = storeData_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    isStore_d   = isStore_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    storeData_d = storeData_q;
    loadData_d  = loadData_q;
`ifdef MISALIGN_TRAP_EN
    mis_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          isStore_d   = isStore;
          funct3_d    = funct3;
          addr_d      = addr;
          storeData_d = storeData;
`ifdef MISALIGN_TRAP_EN
          if (w_mis_in) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
`else
          state_d = S_REQ;
`endif
        end
      end
      S_REQ: begin
        if (isStore_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = LAT_M1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d    = S_DONE;
          loadData_d = w_ext;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are gated by reset so nothing reaches memory while it is held.
  assign memRstrb = (state_q == S_REQ) && !isStore_q && !reset;
  assign memWMask = ((state_q == S_REQ) && isStore_q && !reset) ? w_mask : 4'b0000;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign loadData = loadData_q;
  assign memAddr  = addr_q;
`ifdef MISALIGN_TRAP_EN
  assign misaligned = (state_q == S_DONE) && mis_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// Directed testbench for load_store_unit: one instance at read latency 1 and
// one at read latency 3, driven by the same stimulus.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        isStore = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] storeData = 32'd0;
  logic [31:0] mem_word = 32'h80FF7F01;

  logic        busy1, done1, rstrb1, busy3, done3, rstrb3;
  logic [31:0] ld1, maddr1, wdata1, rdata1, ld3, maddr3, wdata3, rdata3;
  logic [3:0]  wmask1, wmask3;
  logic        mis1, mis3;
  logic        pipe1 = 1'b0;
  logic [2:0]  pipe3 = 3'd0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.RDATA_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .isStore(isStore), .funct3(funct3),
    .addr(addr), .storeData(storeData), .busy(busy1), .done(done1),
    .loadData(ld1), .memAddr(maddr1), .memRstrb(rstrb1), .memRData(rdata1),
    .memWData(wdata1),
`ifdef MISALIGN_TRAP_EN
    .misaligned(mis1),
`endif
    .memWMask(wmask1));

  load_store_unit #(.RDATA_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .isStore(isStore), .funct3(funct3),
    .addr(addr), .storeData(storeData), .busy(busy3), .done(done3),
    .loadData(ld3), .memAddr(maddr3), .memRstrb(rstrb3), .memRData(rdata3),
    .memWData(wdata3),
`ifdef MISALIGN_TRAP_EN
    .misaligned(mis3),
`endif
    .memWMask(wmask3));

`ifndef MISALIGN_TRAP_EN
  assign mis1 = 1'b0;
  assign mis3 = 1'b0;
`endif

  // Memory model: data is valid only RDATA_LATENCY cycles after the strobe.
  always @(posedge clk) begin
    pipe1 <= rstrb1;
    pipe3 <= {pipe3[1:0], rstrb3};
  end
  assign rdata1 = pipe1    ? mem_word : 32'h0BAD0BAD;
  assign rdata3 = pipe3[2] ? mem_word : 32'h0BAD0BAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  logic [31:0] req_addr, req_wdata, done_addr;
  logic [3:0]  req_mask, done_mask;
  int          lat1, lat3, str1, str3, ndone1;
  logic        mis_at;

  // Launch one operation and observe both instances for a bounded window.
  task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] d, input bit poke);
    @(negedge clk);
    start = 1'b1; isStore = st; funct3 = f3; addr = a; storeData = d;
    @(negedge clk);
    start = 1'b0;
    req_addr = maddr1; req_mask = wmask1; req_wdata = wdata1;
    if (poke) begin
      start = 1'b1; addr = 32'h0000FFF0; isStore = ~st;
    end
    lat1 = 0; lat3 = 0; str1 = 0; str3 = 0; ndone1 = 0; mis_at = 1'b0;
    done_mask = 4'hF; done_addr = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 2) start = 1'b0;
      if (rstrb1) str1++;
      if (rstrb3) str3++;
      if (done1) begin
        ndone1++;
        if (lat1 == 0) begin
          lat1 = k; done_mask = wmask1; done_addr = maddr1; mis_at = mis1;
        end
      end
      if (done3 && lat3 == 0) lat3 = k;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy",  {31'd0, busy1}, 32'd0);
    check("rst_done",  {31'd0, done1}, 32'd0);
    check("rst_ld",    ld1, 32'd0);
    check("rst_addr",  maddr1, 32'd0);
    check("rst_rstrb", {31'd0, rstrb1}, 32'd0);
    check("rst_wmask", {28'd0, wmask1}, 32'd0);
    check("rst_wdata", wdata1, 32'd0);

    // Stores
    op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0);
    check("sw_addr",  req_addr, 32'h100);
    check("sw_mask",  {28'd0, req_mask}, 32'hF);
    check("sw_wdata", req_wdata, 32'hDEADBEEF);
    check("sw_lat1",  lat1, 2);
    check("sw_lat3",  lat3, 2);
    check("sw_nostr", str1, 0);
    check("sw_donemask", {28'd0, done_mask}, 32'h0);
    check("idle_hold_addr", maddr1, 32'h100);

    op(1'b1, 3'b000, 32'h103, 32'h000000A5, 1'b0);
    check("sb_mask",  {28'd0, req_mask}, 32'h8);
    check("sb_wdata", req_wdata, 32'hA5A5A5A5);

    op(1'b1, 3'b001, 32'h102, 32'h00001234, 1'b0);
    check("sh_mask",  {28'd0, req_mask}, 32'hC);
    check("sh_wdata", req_wdata, 32'h12341234);

    op(1'b1, 3'b000, 32'h101, 32'h0000003C, 1'b0);
    check("sb1_mask", {28'd0, req_mask}, 32'h2);

    // Loads from word 0x80FF7F01
    op(1'b0, 3'b000, 32'h102, 32'h0, 1'b0);
    check("lb_data",  ld1, 32'hFFFFFFFF);
    check("lb_lat1",  lat1, 3);
    check("lb_str1",  str1, 1);
    check("lb_data3", ld3, 32'hFFFFFFFF);
    op(1'b0, 3'b100, 32'h102, 32'h0, 1'b0);
    check("lbu_data", ld1, 32'h000000FF);
    op(1'b0, 3'b001, 32'h102, 32'h0, 1'b0);
    check("lh_data",  ld1, 32'hFFFF80FF);
    op(1'b0, 3'b101, 32'h102, 32'h0, 1'b0);
    check("lhu_data", ld1, 32'h000080FF);
    op(1'b0, 3'b000, 32'h100, 32'h0, 1'b0);
    check("lb0_data", ld1, 32'h00000001);
    op(1'b0, 3'b101, 32'h100, 32'h0, 1'b0);
    check("lhu0_data", ld3, 32'h00007F01);

    mem_word = 32'h13579BDF;
    op(1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
    check("lw_lat3",  lat3, 5);
    check("lw_str3",  str3, 1);
    check("lw_addr3", maddr3, 32'h40);
    check("lw_data3", ld3, 32'h13579BDF);
    check("lw_data1", ld1, 32'h13579BDF);

    mem_word = 32'h80FF7F01;
    op(1'b0, 3'b010, 32'h101, 32'h0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    check("mis_lat1", lat1, 1);
    check("mis_flag", {31'd0, mis_at}, 32'd1);
    check("mis_nostr", str1, 0);
    check("mis_ld",   ld1, 32'h13579BDF);
`else
    check("unal_lat1", lat1, 3);
    check("unal_str",  str1, 1);
    check("unal_ld",   ld1, 32'h80FF7F01);
    check("unal_flag", {31'd0, mis_at}, 32'd0);
`endif

    // Start while busy must be ignored.
    op(1'b0, 3'b000, 32'h103, 32'h0, 1'b1);
    check("busy_ndone", ndone1, 1);
    check("busy_addr",  done_addr, 32'h103);
    check("busy_ld",    ld1, 32'hFFFFFF80);

    // Reset during REQ: strobe suppressed, no done.
    @(negedge clk);
    start = 1'b1; isStore = 1'b0; funct3 = 3'b010; addr = 32'h200;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    #1;
    check("rstreq_str1", {31'd0, rstrb1}, 32'd0);
    check("rstreq_str3", {31'd0, rstrb3}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("rstreq_busy", {31'd0, busy1}, 32'd0);
    check("rstreq_ld",   ld1, 32'd0);

    // Reset during WAIT on the latency-3 instance.
    @(negedge clk);
    start = 1'b1; addr = 32'h300;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("wait_busy3", {31'd0, busy3}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstwait_busy3", {31'd0, busy3}, 32'd0);
    ndone1 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done3 || done1) ndone1++;
    end
    check("rstwait_nodone", ndone1, 0);
    check("rstwait_addr", maddr3, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
